// File: rtl/ring_monitor_pkg.sv
// ring_monitor_pkg: shared FSM encoding and ring-word helpers for ring counter consumers
package ring_monitor_pkg;

   localparam logic [1:0] ST_UNLOCKED = 2'd0;
   localparam logic [1:0] ST_LOCKED   = 2'd1;
   localparam logic [1:0] ST_FAULT    = 2'd2;

   localparam int RING_MAX_W = 64;

   // Rotate right by one within the low w bits: bit i <- bit i+1, top bit <- bit 0.
   function automatic logic [RING_MAX_W-1:0] rotr(input logic [RING_MAX_W-1:0] v, input int w);
      logic [RING_MAX_W-1:0] r;
      r = '0;
      for (int i = 0; i < RING_MAX_W - 1; i++)
         if (i < w - 1) r[i] = v[i+1];
      r[w-1] = v[0];
      return r;
   endfunction

endpackage

// File: rtl/ring_monitor_if.sv
// ring_monitor_if: ring word in, monitor status out
interface ring_monitor_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8,
   parameter int IDX_W = $clog2(WIDTH)
);
   logic [WIDTH-1:0] ring_in;
   logic             clr_err;
   logic [IDX_W-1:0] idx;
   logic             valid;
   logic             locked;
   logic             err;
   logic [CNT_W-1:0] rot_cnt;
   logic [CNT_W-1:0] err_cnt;

   modport master (output ring_in, clr_err, input idx, valid, locked, err, rot_cnt, err_cnt);
   modport slave  (input ring_in, clr_err, output idx, valid, locked, err, rot_cnt, err_cnt);
endinterface

// File: rtl/ring_monitor_onehot_enc.sv
// onehot_enc: flags a one-hot word and encodes its hot bit to a binary index
module onehot_enc #(
   parameter int WIDTH = 4,
   parameter int IDX_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] vec_i,
   output logic             onehot_o,
   output logic [IDX_W-1:0] idx_o
);

   assign onehot_o = (vec_i != '0) && ((vec_i & (vec_i - WIDTH'(1))) == '0);

   // OR-encode set bit positions; exact whenever the word is one-hot
   always_comb begin
      idx_o = '0;
      for (int i = 0; i < WIDTH; i++)
         if (vec_i[i]) idx_o = idx_o | IDX_W'(i);
   end

endmodule

// File: rtl/ring_monitor.sv
// ring_monitor: checks a rotating one-hot ring, encodes its phase, tracks lock/fault
module ring_monitor #(
   parameter int WIDTH  = 4,
   parameter int LOCK_N = 3,
   parameter int CNT_W  = 8
) (
   input logic           clk,
   input logic           rst,
   ring_monitor_if.slave bus
);
   import ring_monitor_pkg::*;

   localparam int IDX_W = $clog2(WIDTH);
   localparam int RUN_W = $clog2(LOCK_N + 1);

   logic [WIDTH-1:0] s_q, p_q, expected;
   logic             prev_ok_q, onehot, good, wrap;
   logic [IDX_W-1:0] enc_idx, idx_q;
   logic             valid_q, locked_q;
   logic [1:0]       state_q, state_d;
   logic [RUN_W-1:0] run_q, run_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] rot_q, rot_d, errc_q, errc_d;

   onehot_enc #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_enc (
      .vec_i   (s_q),
      .onehot_o(onehot),
      .idx_o   (enc_idx)
   );

   assign expected = WIDTH'(rotr(RING_MAX_W'(p_q), WIDTH));
   assign good     = onehot && prev_ok_q && (s_q == expected);
   assign wrap     = p_q[0];

   // Lock/fault sequencing and counters on stage-2 data
   always_comb begin
      state_d = state_q;
      run_d   = run_q;
      err_d   = err_q;
      rot_d   = rot_q;
      errc_d  = errc_q;
      case (state_q)
         ST_UNLOCKED: begin
            err_d = err_q & ~bus.clr_err;
            run_d = good ? run_q + RUN_W'(1) : '0;
            if (good && run_q == RUN_W'(LOCK_N - 1)) begin
               state_d = ST_LOCKED;
               run_d   = '0;
            end
         end
         ST_LOCKED: begin
            if (good) begin
               err_d = err_q & ~bus.clr_err;
               rot_d = wrap ? rot_q + CNT_W'(1) : rot_q;
            end else begin
               state_d = ST_FAULT;
               err_d   = 1'b1;
               errc_d  = &errc_q ? errc_q : errc_q + CNT_W'(1);
            end
         end
         ST_FAULT: begin
            if (bus.clr_err) begin
               state_d = ST_UNLOCKED;
               err_d   = 1'b0;
               run_d   = '0;
            end
         end
         default: state_d = ST_UNLOCKED;
      endcase
   end

   // Two-stage sample pipeline plus FSM/counter state
   always_ff @(posedge clk) begin
      if (rst) begin
         s_q       <= '0;
         p_q       <= '0;
         prev_ok_q <= 1'b0;
         valid_q   <= 1'b0;
         idx_q     <= '0;
         locked_q  <= 1'b0;
         state_q   <= ST_UNLOCKED;
         run_q     <= '0;
         err_q     <= 1'b0;
         rot_q     <= '0;
         errc_q    <= '0;
      end else begin
         s_q       <= bus.ring_in;
         p_q       <= s_q;
         prev_ok_q <= onehot;
         valid_q   <= onehot;
         if (onehot) idx_q <= enc_idx;
         locked_q  <= state_d == ST_LOCKED;
         state_q   <= state_d;
         run_q     <= run_d;
         err_q     <= err_d;
         rot_q     <= rot_d;
         errc_q    <= errc_d;
      end
   end

   assign bus.idx     = idx_q;
   assign bus.valid   = valid_q;
   assign bus.locked  = locked_q;
   assign bus.err     = err_q;
   assign bus.rot_cnt = rot_q;
   assign bus.err_cnt = errc_q;

endmodule

// File: tb/tb_ring_monitor.sv
// tb_ring_monitor: directed and random checks of ring_monitor against a position-based model
module tb_ring_monitor;
   localparam int W  = 4;
   localparam int LN = 3;
   localparam int CW = 8;
   localparam int IW = $clog2(W);
   localparam int OW = 3 + IW + 2 * CW;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ring_monitor_if #(.WIDTH(W), .CNT_W(CW)) bus ();

   ring_monitor #(.WIDTH(W), .LOCK_N(LN), .CNT_W(CW)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks = 0;
   int fails  = 0;
   int ph     = W - 1;
   logic [W-1:0] last;

   logic [W-1:0]  m_s, m_p;
   logic          m_pok, m_valid, m_locked, m_err;
   logic [IW-1:0] m_idx;
   logic [CW-1:0] m_rot, m_errc;
   int            m_st, m_run;

   logic [OW-1:0] dut_o, mdl_o;
   assign dut_o = {bus.valid, bus.locked, bus.err, bus.idx, bus.rot_cnt, bus.err_cnt};
   assign mdl_o = {m_valid, m_locked, m_err, m_idx, m_rot, m_errc};

   function automatic bit oh(input logic [W-1:0] v);
      return $countones(v) == 1;
   endfunction

   function automatic int pos(input logic [W-1:0] v);
      int p;
      p = 0;
      for (int i = 0; i < W; i++) if (v[i]) p = i;
      return p;
   endfunction

   // Model: state 0=unlocked 1=locked 2=fault; a good step moves the hot position down by one, modulo W
   task automatic model(input logic [W-1:0] r, input logic c, input logic rs);
      bit g;
      int nst;
      if (rs) begin
         m_s = '0; m_p = '0; m_pok = 0; m_st = 0; m_run = 0; m_valid = 0; m_idx = '0;
         m_locked = 0; m_err = 0; m_rot = '0; m_errc = '0;
         return;
      end
      g = oh(m_s) && m_pok && pos(m_s) == (pos(m_p) + W - 1) % W;
      m_valid = oh(m_s);
      if (m_valid) m_idx = IW'(pos(m_s));
      nst = m_st;
      if (m_st == 0) begin
         if (c) m_err = 0;
         if (g) begin
            m_run++;
            if (m_run == LN) begin nst = 1; m_run = 0; end
         end else m_run = 0;
      end else if (m_st == 1) begin
         if (g) begin
            if (c) m_err = 0;
            if (pos(m_p) == 0) m_rot++;
         end else begin
            nst = 2; m_err = 1;
            if (m_errc != '1) m_errc++;
         end
      end else if (c) begin
         nst = 0; m_err = 0; m_run = 0;
      end
      m_st = nst;
      m_locked = nst == 1;
      m_pok = oh(m_s);
      m_p = m_s;
      m_s = r;
   endtask

   task automatic step(input logic [W-1:0] r, input logic c, input logic rs);
      bus.ring_in = r;
      bus.clr_err = c;
      rst = rs;
      last = r;
      @(posedge clk);
      model(r, c, rs);
      @(negedge clk);
      bus.clr_err = 1'b0;
   endtask

   task automatic ring_step(input logic c);
      step(W'(1) << ph, c, 1'b0);
      ph = (ph + W - 1) % W;
   endtask

   task automatic relock();
      ring_step(1'b1);
      for (int k = 0; k < 10 && !bus.locked; k++) ring_step(1'b0);
   endtask

   task automatic test_reset();
      bus.ring_in = '0;
      bus.clr_err = 1'b0;
      step('0, 1'b0, 1'b1);
      step(4'b1000, 1'b0, 1'b1);
      checks++;
      if (dut_o !== '0) begin fails++; $display("FAIL reset: got %h expected 0", dut_o); end
   endtask

   task automatic test_lock();
      ph = W - 1;
      for (int k = 1; k <= 18; k++) begin
         ring_step(1'b0);
         checks++;
         if (dut_o !== mdl_o) begin fails++; $display("FAIL lock_step%0d: got %h expected %h", k, dut_o, mdl_o); end
         if (k == 2) begin
            checks++;
            if (bus.idx !== IW'(3) || bus.valid !== 1'b1) begin fails++; $display("FAIL lock_idx: got %0d/%b expected 3/1", bus.idx, bus.valid); end
         end
         if (k == 4) begin
            checks++;
            if (bus.locked !== 1'b0) begin fails++; $display("FAIL lock_early: got %b expected 0", bus.locked); end
         end
         if (k == 5) begin
            checks++;
            if (bus.locked !== 1'b1 || bus.rot_cnt !== 8'd0) begin fails++; $display("FAIL lock_on: got %b/%h expected 1/00", bus.locked, bus.rot_cnt); end
         end
         if (k == 6) begin
            checks++;
            if (bus.rot_cnt !== 8'd1) begin fails++; $display("FAIL rot_first: got %h expected 01", bus.rot_cnt); end
         end
      end
      checks++;
      if (bus.rot_cnt !== 8'd4) begin fails++; $display("FAIL rot_four: got %h expected 04", bus.rot_cnt); end
   endtask

   task automatic test_fault();
      step(4'b0110, 1'b0, 1'b0);
      ring_step(1'b0);
      checks++;
      if ({bus.valid, bus.locked, bus.err, bus.err_cnt} !== {3'b001, 8'd1}) begin
         fails++; $display("FAIL fault_inject: got v%b l%b e%b c%h expected v0 l0 e1 c01", bus.valid, bus.locked, bus.err, bus.err_cnt);
      end
      for (int k = 0; k < 8; k++) begin
         ring_step(1'b0);
         checks++;
         if (dut_o !== mdl_o) begin fails++; $display("FAIL fault_hold%0d: got %h expected %h", k, dut_o, mdl_o); end
      end
      checks++;
      if ({bus.locked, bus.err, bus.err_cnt} !== {2'b01, 8'd1}) begin fails++; $display("FAIL fault_stay: got l%b e%b c%h expected l0 e1 c01", bus.locked, bus.err, bus.err_cnt); end
   endtask

   task automatic test_clear();
      ring_step(1'b1);
      checks++;
      if (bus.err !== 1'b0 || bus.locked !== 1'b0) begin fails++; $display("FAIL clear_err: got e%b l%b expected e0 l0", bus.err, bus.locked); end
      for (int k = 0; k < 10 && !bus.locked; k++) begin
         ring_step(1'b0);
         checks++;
         if (dut_o !== mdl_o) begin fails++; $display("FAIL clear_relock%0d: got %h expected %h", k, dut_o, mdl_o); end
      end
      checks++;
      if (bus.locked !== 1'b1 || bus.err_cnt !== 8'd1) begin fails++; $display("FAIL clear_locked: got l%b c%h expected l1 c01", bus.locked, bus.err_cnt); end
   endtask

   task automatic test_hold_reverse();
      step(last, 1'b0, 1'b0);
      ring_step(1'b0);
      checks++;
      if ({bus.locked, bus.err, bus.err_cnt} !== {2'b01, 8'd2}) begin fails++; $display("FAIL hold: got l%b e%b c%h expected l0 e1 c02", bus.locked, bus.err, bus.err_cnt); end
      relock();
      checks++;
      if (bus.locked !== 1'b1) begin fails++; $display("FAIL hold_relock: got %b expected 1", bus.locked); end
      step(W'(1) << ((ph + 2) % W), 1'b0, 1'b0);
      ph = (ph + 1) % W;
      ring_step(1'b0);
      checks++;
      if ({bus.locked, bus.err, bus.err_cnt} !== {2'b01, 8'd3}) begin fails++; $display("FAIL reverse: got l%b e%b c%h expected l0 e1 c03", bus.locked, bus.err, bus.err_cnt); end
      checks++;
      if (dut_o !== mdl_o) begin fails++; $display("FAIL reverse_model: got %h expected %h", dut_o, mdl_o); end
   endtask

   task automatic test_saturate_wrap();
      for (int k = 0; k < 300 && bus.err_cnt !== 8'hFF; k++) begin
         relock();
         step('0, 1'b0, 1'b0);
         ring_step(1'b0);
         checks++;
         if (dut_o !== mdl_o) begin fails++; $display("FAIL sat_iter%0d: got %h expected %h", k, dut_o, mdl_o); end
      end
      checks++;
      if (bus.err_cnt !== 8'hFF) begin fails++; $display("FAIL sat_reach: got %h expected ff", bus.err_cnt); end
      relock();
      step('0, 1'b0, 1'b0);
      ring_step(1'b0);
      checks++;
      if (bus.err_cnt !== 8'hFF || bus.err !== 1'b1) begin fails++; $display("FAIL sat_hold: got c%h e%b expected cff e1", bus.err_cnt, bus.err); end
      relock();
      for (int k = 0; k < 1100 && bus.rot_cnt !== 8'hFF; k++) begin
         ring_step(1'b0);
         checks++;
         if (dut_o !== mdl_o) begin fails++; $display("FAIL rot_run%0d: got %h expected %h", k, dut_o, mdl_o); end
      end
      checks++;
      if (bus.rot_cnt !== 8'hFF) begin fails++; $display("FAIL rot_reach: got %h expected ff", bus.rot_cnt); end
      for (int k = 0; k < W; k++) ring_step(1'b0);
      checks++;
      if (bus.rot_cnt !== 8'h00 || bus.locked !== 1'b1) begin fails++; $display("FAIL rot_wrap: got %h/%b expected 00/1", bus.rot_cnt, bus.locked); end
   endtask

   task automatic test_midrun_reset();
      step(W'(1) << ph, 1'b0, 1'b1);
      checks++;
      if (dut_o !== '0) begin fails++; $display("FAIL mid_reset: got %h expected 0", dut_o); end
      for (int k = 1; k <= 5; k++) begin
         ring_step(1'b0);
         checks++;
         if (dut_o !== mdl_o) begin fails++; $display("FAIL post_reset%0d: got %h expected %h", k, dut_o, mdl_o); end
         if (k == 4) begin
            checks++;
            if (bus.locked !== 1'b0) begin fails++; $display("FAIL post_reset_early: got %b expected 0", bus.locked); end
         end
         if (k == 5) begin
            checks++;
            if (bus.locked !== 1'b1) begin fails++; $display("FAIL post_reset_lock: got %b expected 1", bus.locked); end
         end
      end
   endtask

   task automatic test_random();
      int r;
      logic c, rs;
      for (int k = 0; k < 1500; k++) begin
         r  = $urandom_range(0, 19);
         c  = $urandom_range(0, 9) == 0;
         rs = $urandom_range(0, 199) == 0;
         if (r == 0) step(W'($urandom), c, rs);
         else if (r == 1) step(last, c, rs);
         else if (r == 2) step(W'(1) << ((ph + 2) % W), c, rs);
         else begin
            step(W'(1) << ph, c, rs);
            ph = (ph + W - 1) % W;
         end
         checks++;
         if (dut_o !== mdl_o) begin fails++; $display("FAIL random%0d: got %h expected %h", k, dut_o, mdl_o); end
      end
   endtask

   initial begin
      test_reset();
      test_lock();
      test_fault();
      test_clear();
      test_hold_reverse();
      test_saturate_wrap();
      test_midrun_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
      $finish;
   end

endmodule
